rf_wb_arbiter: RTL

- Shares the register file's single write port between two requesters: the in-order pipeline writeback (port P) and a multi-cycle unit such as a load or mul/div unit (port M).
- Buffers M results in a small pending FIFO and tracks pending destinations, so RAW and WAW hazards against in-flight M results are stalled or squashed.
- Sits between the writeback stage / multi-cycle unit and the register file write inputs (rd, wb, RegWen).

---
 rtl/rf_wb_arbiter_pkg.sv | 25 ++
 rtl/rf_wb_arbiter_if.sv | 55 +++++
 rtl/rf_wb_arbiter_pend_fifo.sv | 89 ++++++++
 rtl/rf_wb_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// ============================================================================
// Module : rf_arb_pkg
// Brief  : Shared widths, pending-entry type and grant encoding for rf_wb_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_arb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            squash;
    } pend_entry_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_P    = 2'd1;
    localparam logic [1:0] GNT_M    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// Module : rf_wb_arbiter_if
// Brief  : Request, hazard and register-file write signals of rf_wb_arbiter.
//          Forwarding signals exist only when RF_ARB_BYPASS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if;
    import rf_arb_pkg::*;

    logic            p_valid;
    logic [AW-1:0]   p_rd;
    logic [XLEN-1:0] p_data;
    logic            p_stall;
    logic            m_valid;
    logic            m_ready;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_data;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            hazard_stall;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            busy;
`ifdef RF_ARB_BYPASS_EN
    logic            fwd_a_hit;
    logic            fwd_b_hit;
    logic [XLEN-1:0] fwd_data;

    modport slave (
        input  p_valid, p_rd, p_data, m_valid, m_rd, m_data, rs1, rs2,
        output p_stall, m_ready, hazard_stall, rf_we, rf_rd, rf_wdata, busy,
               fwd_a_hit, fwd_b_hit, fwd_data
    );
    modport master (
        output p_valid, p_rd, p_data, m_valid, m_rd, m_data, rs1, rs2,
        input  p_stall, m_ready, hazard_stall, rf_we, rf_rd, rf_wdata, busy,
               fwd_a_hit, fwd_b_hit, fwd_data
    );
`else
    modport slave (
        input  p_valid, p_rd, p_data, m_valid, m_rd, m_data, rs1, rs2,
        output p_stall, m_ready, hazard_stall, rf_we, rf_rd, rf_wdata, busy
    );
    modport master (
        output p_valid, p_rd, p_data, m_valid, m_rd, m_data, rs1, rs2,
        input  p_stall, m_ready, hazard_stall, rf_we, rf_rd, rf_wdata, busy
    );
`endif

endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter_pend_fifo.sv
// ============================================================================
// Module : rf_pend_fifo
// Brief  : Pending M-result FIFO with squash-by-rd and parallel source match.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_pend_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            push_i,
    input  wire logic [AW-1:0]   push_rd_i,
    input  wire logic [XLEN-1:0] push_data_i,
    input  wire logic            pop_i,
    input  wire logic            sq_en_i,
    input  wire logic [AW-1:0]   sq_rd_i,
    input  wire logic [AW-1:0]   rs1_i,
    input  wire logic [AW-1:0]   rs2_i,
    output pend_entry_t          head_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 rs1_match_o,
    output logic                 rs2_match_o
);

    localparam int PW = $clog2(DEPTH);

    pend_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [PW:0]        wr_ptr_q;
    logic [PW:0]        rd_ptr_q;
    logic [PW-1:0]      w_wr_idx;
    logic [PW-1:0]      w_rd_idx;
    pend_entry_t        w_new;

    assign w_wr_idx = wr_ptr_q[PW-1:0];
    assign w_rd_idx = rd_ptr_q[PW-1:0];
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (w_wr_idx == w_rd_idx);
    assign head_o   = mem_q[w_rd_idx];

    // An entry written in the same cycle a newer P write targets its rd is born squashed.
    always_comb begin
        w_new        = '0;
        w_new.rd     = push_rd_i;
        w_new.data   = push_data_i;
        w_new.squash = sq_en_i && (sq_rd_i == push_rd_i);
    end

    always_comb begin
        rs1_match_o = 1'b0;
        rs2_match_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !mem_q[i].squash) begin
                if (mem_q[i].rd == rs1_i) rs1_match_o = 1'b1;
                if (mem_q[i].rd == rs2_i) rs2_match_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sq_en_i && vld_q[i] && (mem_q[i].rd == sq_rd_i)) mem_q[i].squash <= 1'b1;
            end
            if (pop_i) begin
                vld_q[w_rd_idx] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
            if (push_i) begin
                mem_q[w_wr_idx] <= w_new;
                vld_q[w_wr_idx] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module : rf_wb_arbiter
// Brief  : Shares the register-file write port between pipeline writeback and
//          a multi-cycle unit; optional forwarding under RF_ARB_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    rf_wb_arbiter_if.slave  bus
);

    localparam int            WW     = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] C_MAXW = WW'(MAX_WAIT);

    logic [WW-1:0]   wait_q, wait_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    pend_entry_t     w_head;
    logic            w_empty, w_full, w_push, w_pop, w_force, w_sq_en;
    logic            w_m1, w_m2, w_h1, w_h2;
    logic [1:0]      w_gnt;

    assign w_force = (wait_q == C_MAXW) && !w_empty;
    assign w_push  = bus.m_valid && !w_full && (bus.m_rd != '0);
    assign w_pop   = (w_gnt == GNT_M);
    assign w_sq_en = (w_gnt == GNT_P) && (bus.p_rd != '0);

    rf_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_rd_i   (bus.m_rd),
        .push_data_i (bus.m_data),
        .pop_i       (w_pop),
        .sq_en_i     (w_sq_en),
        .sq_rd_i     (bus.p_rd),
        .rs1_i       (bus.rs1),
        .rs2_i       (bus.rs2),
        .head_o      (w_head),
        .empty_o     (w_empty),
        .full_o      (w_full),
        .rs1_match_o (w_m1),
        .rs2_match_o (w_m2)
    );

    always_comb begin
        w_gnt      = GNT_NONE;
        wait_d     = wait_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (w_force)           w_gnt = GNT_M;
        else if (bus.p_valid)  w_gnt = GNT_P;
        else if (!w_empty)     w_gnt = GNT_M;
        // x0 writes and squashed entries consume their grant without writing.
        unique case (w_gnt)
            GNT_P: if (bus.p_rd != '0) begin
                rf_we_d    = 1'b1;
                rf_rd_d    = bus.p_rd;
                rf_wdata_d = bus.p_data;
            end
            GNT_M: if (!w_head.squash) begin
                rf_we_d    = 1'b1;
                rf_rd_d    = w_head.rd;
                rf_wdata_d = w_head.data;
            end
            default: ;
        endcase
        if (w_empty || w_pop)                          wait_d = '0;
        else if ((w_gnt == GNT_P) && (wait_q != C_MAXW)) wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            wait_q     <= wait_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef RF_ARB_BYPASS_EN
    assign w_h1          = (bus.rs1 != '0) && (w_m1 || (w_push && (bus.m_rd == bus.rs1)));
    assign w_h2          = (bus.rs2 != '0) && (w_m2 || (w_push && (bus.m_rd == bus.rs2)));
    assign bus.fwd_a_hit = rf_we_q && (rf_rd_q == bus.rs1);
    assign bus.fwd_b_hit = rf_we_q && (rf_rd_q == bus.rs2);
    assign bus.fwd_data  = rf_wdata_q;
`else
    // Without forwarding, a write landing this cycle is not yet readable by decode.
    assign w_h1 = (bus.rs1 != '0) && (w_m1 || (w_push && (bus.m_rd == bus.rs1))
                                      || (rf_we_q && (rf_rd_q == bus.rs1)));
    assign w_h2 = (bus.rs2 != '0) && (w_m2 || (w_push && (bus.m_rd == bus.rs2))
                                      || (rf_we_q && (rf_rd_q == bus.rs2)));
`endif

    assign bus.hazard_stall = w_h1 || w_h2;
    assign bus.p_stall      = w_force && bus.p_valid;
    assign bus.m_ready      = !w_full;
    assign bus.busy         = !w_empty;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_rd        = rf_rd_q;
    assign bus.rf_wdata     = rf_wdata_q;

endmodule

`default_nettype wire
